// File: rtl/spi_cmd_master_pkg.sv
// Shared definitions for the synth command SPI master: command codes,
// frame layout helpers and the frame FSM state encoding.
package spi_cmd_master_pkg;

  localparam logic [7:0] CMD_FREQ1 = 8'h01;
  localparam logic [7:0] CMD_ENV1  = 8'h02;
  localparam logic [7:0] CMD_FREQ2 = 8'h03;
  localparam logic [7:0] CMD_ENV2  = 8'h04;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StGap,
    StHold,
    StCooldown
  } state_e;

  // Number of bytes on the wire for a command; 0 marks an unsupported code.
  function automatic logic [1:0] frame_bytes(input logic [7:0] code);
    logic [1:0] n;
    case (code)
      CMD_FREQ1, CMD_FREQ2: n = 2'd3;
      CMD_ENV1, CMD_ENV2:   n = 2'd2;
      default:              n = 2'd0;
    endcase
    return n;
  endfunction

  // Byte at position idx of the frame; byte 0 is always the command code.
  function automatic logic [7:0] frame_byte(input logic [7:0]  code,
                                            input logic [15:0] data,
                                            input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = code;
      2'd1:    b = (frame_bytes(code) == 2'd3) ? data[15:8] : data[7:0];
      default: b = data[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte engine: clock divider plus MSB-first mosi / miso shifting.
// load_i presents a byte on mosi ahead of start_i; done_o is high during the
// last clk cycle of the byte so a controller can chain without dead cycles.
module spi_byte_shifter #(
  parameter int unsigned ClkDiv = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       start_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       done_o,
  output logic [7:0] rx_o
);

  localparam int unsigned DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);

  logic            active_q;
  logic            sclk_q;
  logic [DivW-1:0] div_q;
  logic [2:0]      bit_q;
  logic [7:0]      tx_q;
  logic [7:0]      rx_q;
  logic            phase_end;

  assign phase_end = active_q && (div_q == DivLast);
  assign done_o    = phase_end && sclk_q && (bit_q == 3'd7);
  assign sclk_o    = sclk_q;
  assign mosi_o    = tx_q[7];
  assign rx_o      = rx_q;

  // Half-period divider, sclk generation and data shifting.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= 3'd0;
      tx_q     <= 8'h00;
      rx_q     <= 8'h00;
    end else begin
      if (start_i && !active_q) begin
        active_q <= 1'b1;
        sclk_q   <= 1'b0;
        div_q    <= '0;
        bit_q    <= 3'd0;
      end else if (active_q) begin
        if (phase_end) begin
          div_q  <= '0;
          sclk_q <= ~sclk_q;
          if (!sclk_q) begin
            rx_q <= {rx_q[6:0], miso_i};
          end else begin
            tx_q <= {tx_q[6:0], 1'b0};
            if (bit_q == 3'd7) begin
              active_q <= 1'b0;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end else begin
          div_q <= div_q + DivW'(1);
        end
      end
      // A load on the final falling edge replaces the drained shift data.
      if (load_i) begin
        tx_q <= data_i;
      end
    end
  end

endmodule

// File: rtl/spi_cmd_master.sv
// Frame-level SPI master for dds control commands: accepts a command,
// frames it with nss set-up / inter-byte gap / hold timing and reports the
// miso byte seen during the final byte.
module spi_cmd_master
  import spi_cmd_master_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CS_SETUP   = 4,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_code,
  input  logic [15:0] cmd_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  rx_byte,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_nss,
  input  logic        spi_miso
);

  localparam int unsigned Max1   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned DlyMax = (Max1 > GAP_CYCLES) ? Max1 : GAP_CYCLES;
  localparam int unsigned DlyW   = (DlyMax > 1) ? $clog2(DlyMax) : 1;
  localparam logic [DlyW-1:0] SetupLast = DlyW'(CS_SETUP - 1);
  localparam logic [DlyW-1:0] GapLast   = DlyW'(GAP_CYCLES - 1);

  state_e          state_q;
  logic [DlyW-1:0] dly_q;
  logic [1:0]      idx_q;
  logic [1:0]      nbytes_q;
  logic [7:0]      code_q;
  logic [15:0]     data_q;
  logic            nss_q;
  logic            ready_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [7:0]      rx_q;

  logic            accept;
  logic [1:0]      cmd_nbytes;
  logic            more_bytes;
  logic            shf_load;
  logic [7:0]      shf_data;
  logic            shf_start;
  logic            shf_done;
  logic [7:0]      shf_rx;

  assign accept     = cmd_valid && ready_q;
  assign cmd_nbytes = frame_bytes(cmd_code);
  assign more_bytes = (idx_q + 2'd1) != nbytes_q;

  // Shifter control: preload byte 0 on accept, the next byte as a byte ends,
  // and start shifting on the final cycle of SETUP or GAP.
  always_comb begin
    shf_load  = 1'b0;
    shf_data  = 8'h00;
    shf_start = 1'b0;
    if (state_q == StIdle && accept && cmd_nbytes != 2'd0) begin
      shf_load = 1'b1;
      shf_data = cmd_code;
    end else if (state_q == StShift && shf_done && more_bytes) begin
      shf_load = 1'b1;
      shf_data = frame_byte(code_q, data_q, idx_q + 2'd1);
    end
    if ((state_q == StSetup && dly_q == SetupLast) || (state_q == StGap && dly_q == GapLast)) begin
      shf_start = 1'b1;
    end
  end

  spi_byte_shifter #(
    .ClkDiv (CLK_DIV)
  ) u_shifter (
    .clk_i   (clk),
    .rst_ni  (nreset),
    .load_i  (shf_load),
    .data_i  (shf_data),
    .start_i (shf_start),
    .miso_i  (spi_miso),
    .sclk_o  (spi_sclk),
    .mosi_o  (spi_mosi),
    .done_o  (shf_done),
    .rx_o    (shf_rx)
  );

  // Frame FSM with registered handshake, status and chip-select outputs.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= StIdle;
      dly_q    <= '0;
      idx_q    <= 2'd0;
      nbytes_q <= 2'd0;
      code_q   <= 8'h00;
      data_q   <= 16'h0000;
      nss_q    <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rx_q     <= 8'h00;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            code_q   <= cmd_code;
            data_q   <= cmd_data;
            nbytes_q <= cmd_nbytes;
            idx_q    <= 2'd0;
            dly_q    <= '0;
            if (cmd_nbytes == 2'd0) begin
              err_q <= 1'b1;
            end else begin
              state_q <= StSetup;
              nss_q   <= 1'b0;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        StSetup: begin
          if (dly_q == SetupLast) begin
            state_q <= StShift;
            dly_q   <= '0;
          end else begin
            dly_q <= dly_q + DlyW'(1);
          end
        end
        StShift: begin
          if (shf_done) begin
            dly_q <= '0;
            if (more_bytes) begin
              idx_q   <= idx_q + 2'd1;
              state_q <= StGap;
            end else begin
              state_q <= StHold;
            end
          end
        end
        StGap: begin
          if (dly_q == GapLast) begin
            state_q <= StShift;
            dly_q   <= '0;
          end else begin
            dly_q <= dly_q + DlyW'(1);
          end
        end
        StHold: begin
          if (dly_q == SetupLast) begin
            nss_q   <= 1'b1;
            rx_q    <= shf_rx;
            state_q <= StCooldown;
            dly_q   <= '0;
          end else begin
            dly_q <= dly_q + DlyW'(1);
          end
        end
        StCooldown: begin
          // done follows the nss rise by one cycle.
          if (dly_q == '0) begin
            done_q <= 1'b1;
          end
          if (dly_q == GapLast) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            dly_q   <= '0;
          end else begin
            dly_q <= dly_q + DlyW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rx_byte   = rx_q;
  assign spi_nss   = nss_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Self-checking bench for spi_cmd_master: a negedge bus monitor decodes
// frames, a slave model drives miso, and each test compares against
// expectations computed from the command map and timing formulas.
module tb_spi_cmd_master;

  localparam int ClkDiv    = 2;
  localparam int CsSetup   = 4;
  localparam int GapCycles = 16;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_code = 8'h00;
  logic [15:0] cmd_data = 16'h0000;
  logic        cmd_ready, busy, done, err;
  logic [7:0]  rx_byte;
  logic        spi_sclk, spi_mosi, spi_nss, spi_miso;

  always #5 clk = ~clk;

  spi_cmd_master #(
    .CLK_DIV    (ClkDiv),
    .CS_SETUP   (CsSetup),
    .GAP_CYCLES (GapCycles)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_code  (cmd_code),
    .cmd_data  (cmd_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rx_byte   (rx_byte),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_nss   (spi_nss),
    .spi_miso  (spi_miso)
  );

  int checks = 0;
  int fails = 0;

  // Monitor state.
  int          cyc = 0;
  int          rise_cnt = 0;
  int          low_len = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          idle_toggles = 0;
  int          ready_busy = 0;
  int          last_rise_cyc = 0;
  int          done_cyc = 0;
  logic [7:0]  done_rx = 8'h00;
  logic        prev_nss = 1'b1;
  logic        prev_sclk = 1'b0;
  bit          have_rise = 1'b0;
  logic [31:0] cur_val = 32'h0;
  logic [31:0] frm_val[$];
  int          frm_rises[$];
  int          frm_len[$];
  int          gaps[$];

  logic [7:0]  miso_bytes[3];

  // Bus monitor sampling away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prev_nss && !spi_nss) begin
      rise_cnt = 0;
      cur_val  = 32'h0;
      low_len  = 0;
      if (have_rise) gaps.push_back(cyc - last_rise_cyc);
    end
    if (!spi_nss) low_len = low_len + 1;
    if (busy && cmd_ready) ready_busy = ready_busy + 1;
    if (!prev_sclk && spi_sclk) begin
      rise_cnt = rise_cnt + 1;
      cur_val  = {cur_val[30:0], spi_mosi};
    end
    if (spi_nss && (spi_sclk !== prev_sclk)) idle_toggles = idle_toggles + 1;
    if (!prev_nss && spi_nss) begin
      frm_val.push_back(cur_val);
      frm_rises.push_back(rise_cnt);
      frm_len.push_back(low_len);
      last_rise_cyc = cyc;
      have_rise = 1'b1;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      done_rx  = rx_byte;
    end
    if (err) err_cnt = err_cnt + 1;
    prev_nss  = spi_nss;
    prev_sclk = spi_sclk;
  end

  // Slave model: MSB-first miso, one byte per frame position.
  always_comb begin
    logic [1:0] bi;
    logic [2:0] bsel;
    bi   = (rise_cnt >= 16) ? 2'd2 : 2'(rise_cnt / 8);
    bsel = 3'(7 - (rise_cnt % 8));
    spi_miso = miso_bytes[bi][bsel];
  end

  // Reference model derived from the command map and timing rules.
  function automatic int exp_nbytes(input logic [7:0] c);
    if (c == 8'h01 || c == 8'h03) return 3;
    if (c == 8'h02 || c == 8'h04) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] exp_val(input logic [7:0] c, input logic [15:0] d);
    if (exp_nbytes(c) == 3) return {8'h00, c, d};
    return {16'h0000, c, d[7:0]};
  endfunction

  function automatic int exp_len(input int n);
    return 2 * CsSetup + 16 * ClkDiv * n + (n - 1) * GapCycles;
  endfunction

  // All tasks start and end at posedge + #1.
  task automatic send_cmd(input logic [7:0] c, input logic [15:0] d);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      checks++; fails++;
      $display("FAIL send_timeout cmd_ready got %b want 1", cmd_ready);
    end
    cmd_code  = c;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_code  = 8'($urandom);
    cmd_data  = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || cmd_ready !== 1'b1) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      checks++; fails++;
      $display("FAIL idle_timeout busy got %b want 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (spi_nss !== 1'b1) begin fails++; $display("FAIL rst_nss got %b want 1", spi_nss); end
    checks++; if (spi_sclk !== 1'b0) begin fails++; $display("FAIL rst_sclk got %b want 0", spi_sclk); end
    checks++; if (spi_mosi !== 1'b0) begin fails++; $display("FAIL rst_mosi got %b want 0", spi_mosi); end
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got %b want 0", err); end
    checks++; if (rx_byte !== 8'h00) begin fails++; $display("FAIL rst_rx got %h want 00", rx_byte); end
    nreset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_freq1();
    int f0, d0, t0;
    f0 = frm_val.size(); d0 = done_cnt; t0 = idle_toggles;
    send_cmd(8'h01, 16'h1234);
    wait_idle();
    checks++; if (frm_val.size() != f0 + 1) begin fails++; $display("FAIL freq1_frames got %0d want %0d", frm_val.size() - f0, 1); end
    if (frm_val.size() == f0 + 1) begin
      checks++; if (frm_val[f0] !== 32'h00011234) begin fails++; $display("FAIL freq1_mosi got %h want 00011234", frm_val[f0]); end
      checks++; if (frm_rises[f0] != 24) begin fails++; $display("FAIL freq1_rises got %0d want 24", frm_rises[f0]); end
      checks++; if (frm_len[f0] != exp_len(3)) begin fails++; $display("FAIL freq1_nss_len got %0d want %0d", frm_len[f0], exp_len(3)); end
    end
    checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL freq1_done_cnt got %0d want 1", done_cnt - d0); end
    checks++; if (done_cyc - last_rise_cyc != 1) begin fails++; $display("FAIL freq1_done_delay got %0d want 1", done_cyc - last_rise_cyc); end
    checks++; if (idle_toggles != t0) begin fails++; $display("FAIL freq1_idle_sclk got %0d want %0d", idle_toggles, t0); end
  endtask

  task automatic test_env2();
    int f0, d0;
    f0 = frm_val.size(); d0 = done_cnt;
    send_cmd(8'h04, 16'hBEAB);
    wait_idle();
    checks++; if (frm_val.size() != f0 + 1) begin fails++; $display("FAIL env2_frames got %0d want 1", frm_val.size() - f0); end
    if (frm_val.size() == f0 + 1) begin
      checks++; if (frm_val[f0] !== 32'h000004AB) begin fails++; $display("FAIL env2_mosi got %h want 000004ab", frm_val[f0]); end
      checks++; if (frm_rises[f0] != 16) begin fails++; $display("FAIL env2_rises got %0d want 16", frm_rises[f0]); end
      checks++; if (frm_len[f0] != 2 * CsSetup + 32 * ClkDiv + GapCycles) begin
        fails++; $display("FAIL env2_nss_len got %0d want %0d", frm_len[f0], 2 * CsSetup + 32 * ClkDiv + GapCycles);
      end
    end
    checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL env2_done_cnt got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_invalid();
    int f0, d0, e0, t0;
    f0 = frm_val.size(); d0 = done_cnt; e0 = err_cnt; t0 = idle_toggles;
    send_cmd(8'h07, 16'hFFFF);
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL inv_err_pulse got %b want 1", err); end
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL inv_ready got %b want 1", cmd_ready); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL inv_err_cnt got %0d want 1", err_cnt - e0); end
    checks++; if (frm_val.size() != f0) begin fails++; $display("FAIL inv_frames got %0d want 0", frm_val.size() - f0); end
    checks++; if (idle_toggles != t0) begin fails++; $display("FAIL inv_sclk got %0d want %0d", idle_toggles, t0); end
    checks++; if (spi_nss !== 1'b1) begin fails++; $display("FAIL inv_nss got %b want 1", spi_nss); end
    checks++; if (done_cnt != d0) begin fails++; $display("FAIL inv_done got %0d want %0d", done_cnt, d0); end
  endtask

  task automatic test_miso();
    int f0;
    f0 = frm_val.size();
    miso_bytes[0] = 8'h11; miso_bytes[1] = 8'h22; miso_bytes[2] = 8'h5A;
    send_cmd(8'h03, 16'h0100);
    wait_idle();
    checks++; if (done_rx !== 8'h5A) begin fails++; $display("FAIL miso_rx_at_done got %h want 5a", done_rx); end
    checks++; if (rx_byte !== 8'h5A) begin fails++; $display("FAIL miso_rx_byte got %h want 5a", rx_byte); end
    if (frm_val.size() == f0 + 1) begin
      checks++; if (frm_val[f0] !== 32'h00030100) begin fails++; $display("FAIL miso_mosi got %h want 00030100", frm_val[f0]); end
    end else begin
      checks++; fails++; $display("FAIL miso_frames got %0d want 1", frm_val.size() - f0);
    end
  endtask

  task automatic test_back_to_back();
    int f0, d0, g0, r0, n;
    f0 = frm_val.size(); d0 = done_cnt; g0 = gaps.size(); r0 = ready_busy;
    cmd_code = 8'h01; cmd_data = 16'h0001; cmd_valid = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
    cmd_code = 8'h02; cmd_data = 16'h0080;
    while (busy !== 1'b0 && n < 2000) begin @(posedge clk); #1; n++; end
    while (busy !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
    cmd_valid = 1'b0;
    if (n >= 2000) begin checks++; fails++; $display("FAIL b2b_timeout busy got %b want toggle", busy); end
    wait_idle();
    repeat (50) @(posedge clk);
    #1;
    checks++; if (frm_val.size() != f0 + 2) begin fails++; $display("FAIL b2b_frames got %0d want 2", frm_val.size() - f0); end
    if (frm_val.size() == f0 + 2) begin
      checks++; if (frm_val[f0] !== 32'h00010001) begin fails++; $display("FAIL b2b_first got %h want 00010001", frm_val[f0]); end
      checks++; if (frm_val[f0 + 1] !== 32'h00000280) begin fails++; $display("FAIL b2b_second got %h want 00000280", frm_val[f0 + 1]); end
    end
    checks++; if (done_cnt - d0 != 2) begin fails++; $display("FAIL b2b_done got %0d want 2", done_cnt - d0); end
    checks++; if (ready_busy != r0) begin fails++; $display("FAIL b2b_ready_low got %0d want %0d", ready_busy, r0); end
    if (gaps.size() > g0) begin
      checks++; if (gaps[gaps.size() - 1] < GapCycles) begin fails++; $display("FAIL b2b_gap got %0d want >= %0d", gaps[gaps.size() - 1], GapCycles); end
    end else begin
      checks++; fails++; $display("FAIL b2b_gap_missing got %0d want 1", gaps.size() - g0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0, f0, n;
    send_cmd(8'h01, 16'h1234);
    @(posedge clk); #1;
    n = 0;
    while (rise_cnt < 20 && n < 2000) begin @(posedge clk); #1; n++; end
    if (n >= 2000) begin checks++; fails++; $display("FAIL midrst_timeout rises got %0d want 20", rise_cnt); end
    d0 = done_cnt;
    nreset = 1'b0;
    @(posedge clk); #1;
    checks++; if (spi_nss !== 1'b1) begin fails++; $display("FAIL midrst_nss got %b want 1", spi_nss); end
    checks++; if (spi_sclk !== 1'b0) begin fails++; $display("FAIL midrst_sclk got %b want 0", spi_sclk); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", busy); end
    nreset = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    checks++; if (done_cnt != d0) begin fails++; $display("FAIL midrst_no_done got %0d want %0d", done_cnt, d0); end
    f0 = frm_val.size(); d0 = done_cnt;
    send_cmd(8'h02, 16'h0011);
    wait_idle();
    if (frm_val.size() == f0 + 1) begin
      checks++; if (frm_val[f0] !== 32'h00000211) begin fails++; $display("FAIL midrst_next got %h want 00000211", frm_val[f0]); end
      checks++; if (frm_rises[f0] != 16) begin fails++; $display("FAIL midrst_rises got %0d want 16", frm_rises[f0]); end
    end else begin
      checks++; fails++; $display("FAIL midrst_frames got %0d want 1", frm_val.size() - f0);
    end
    checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL midrst_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [7:0]  c;
      logic [15:0] d;
      int          nb, f0, d0, e0;
      c = 8'($urandom_range(1, 5));
      if (c == 8'h05) begin
        c = 8'($urandom);
        if (c >= 8'h01 && c <= 8'h04) c = 8'hC3;
      end
      d = 16'($urandom);
      for (int k = 0; k < 3; k++) miso_bytes[k] = 8'($urandom);
      nb = exp_nbytes(c);
      f0 = frm_val.size(); d0 = done_cnt; e0 = err_cnt;
      send_cmd(c, d);
      wait_idle();
      repeat (2) @(posedge clk);
      #1;
      if (nb == 0) begin
        checks++; if (err_cnt - e0 != 1 || frm_val.size() != f0) begin
          fails++; $display("FAIL rnd_invalid code %h err %0d frames %0d want 1 0", c, err_cnt - e0, frm_val.size() - f0);
        end
      end else if (frm_val.size() == f0 + 1) begin
        checks++; if (frm_val[f0] !== exp_val(c, d)) begin fails++; $display("FAIL rnd_mosi got %h want %h", frm_val[f0], exp_val(c, d)); end
        checks++; if (frm_len[f0] != exp_len(nb)) begin fails++; $display("FAIL rnd_len got %0d want %0d", frm_len[f0], exp_len(nb)); end
        checks++; if (rx_byte !== miso_bytes[nb - 1]) begin fails++; $display("FAIL rnd_rx got %h want %h", rx_byte, miso_bytes[nb - 1]); end
        checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL rnd_done got %0d want 1", done_cnt - d0); end
      end else begin
        checks++; fails++; $display("FAIL rnd_frames code %h got %0d want 1", c, frm_val.size() - f0);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) miso_bytes[k] = 8'h00;
    test_reset();
    test_freq1();
    test_env2();
    test_invalid();
    test_miso();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
